// File: rtl/sdram_sched_pkg.sv
// Shared types and field widths for the SDRAM request scheduler.
package sdram_sched_pkg;

  localparam int ADDR_W = 24;
  localparam int LEN_W  = 9;
  localparam int BUF_AW = 8;
  localparam int BUF_DW = 32;
  localparam int WR_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OWN,
    ST_SET_A,
    ST_SET_LEN,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer advances only when enabled.
module rr_arb2
  import sdram_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // Client that wins a tie on the next arbitration.
  logic prio_q;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[prio_q])       gnt_o[prio_q]  = 1'b1;
    else if (req_i[!prio_q]) gnt_o[!prio_q] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  prio_q <= 1'b0;
    else if (en_i && |req_i)  prio_q <= gnt_o[0];
  end

endmodule

// File: rtl/sdram_sched.sv
// Two-client SDRAM MAC scheduler: grants ownership, programs address/length, waits for completion.
// Optional MAC busy watchdog enabled by defining SDRAM_SCHED_TMO_EN.
module sdram_sched
  import sdram_sched_pkg::*;
#(
  parameter int TMO_W = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ,
  input  logic [1:0]  REQ_WR,
  input  logic [1:0]  GO,
  input  logic [47:0] REQ_ADDR,
  input  logic [17:0] REQ_LEN,
  input  logic [15:0] BUF_ADDR,
  input  logic [63:0] BUF_WD,
  input  logic [1:0]  BUF_WE,
  output logic [1:0]  GNT,
  output logic [1:0]  DONE,
  output logic [31:0] BUF_RD,
  output logic [7:0]  MAC_ADDR,
  output logic [31:0] MAC_WD,
  output logic        MAC_WE,
  output logic        MAC_WE_LEN,
  output logic        MAC_WE_A,
  input  logic [31:0] MAC_RD,
  input  logic        MAC_BUSY,
  output logic        ERR
);

  typedef logic [TMO_W-1:0] tmo_t;

  state_e              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                lat_wr_q, lat_wr_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [LEN_W-1:0]    lat_len_q, lat_len_d;
  logic [1:0]          arb_gnt;
  logic                gidx;
  logic                tmo_hit;

  assign gidx   = gnt_q[1];
  assign GNT    = gnt_q;
  assign BUF_RD = MAC_RD;

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst   (RESET),
    .req_i (REQ),
    .en_i  (state_q == ST_IDLE),
    .gnt_o (arb_gnt)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    lat_wr_d   = lat_wr_q;
    lat_addr_d = lat_addr_q;
    lat_len_d  = lat_len_q;
    MAC_ADDR   = '0;
    MAC_WD     = '0;
    MAC_WE     = 1'b0;
    MAC_WE_A   = 1'b0;
    MAC_WE_LEN = 1'b0;
    DONE       = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          gnt_d   = arb_gnt;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        MAC_ADDR = BUF_ADDR[gidx*BUF_AW +: BUF_AW];
        MAC_WD   = BUF_WD[gidx*BUF_DW +: BUF_DW];
        MAC_WE   = BUF_WE[gidx];
        if (!REQ[gidx]) begin
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end else if (GO[gidx]) begin
          lat_wr_d   = REQ_WR[gidx];
          lat_addr_d = REQ_ADDR[gidx*ADDR_W +: ADDR_W];
          lat_len_d  = REQ_LEN[gidx*LEN_W +: LEN_W];
          state_d    = ST_SET_A;
        end
      end
      ST_SET_A: begin
        MAC_WD = BUF_DW'(lat_addr_q);
        if (!MAC_BUSY) begin
          MAC_WE_A = 1'b1;
          state_d  = ST_SET_LEN;
        end
      end
      ST_SET_LEN: begin
        MAC_WD         = BUF_DW'(lat_len_q);
        MAC_WD[WR_BIT] = lat_wr_q;
        MAC_WE_LEN     = 1'b1;
        state_d        = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tmo_hit)       state_d = ST_DONE;
        else if (MAC_BUSY) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tmo_hit || !MAC_BUSY) state_d = ST_DONE;
      end
      ST_DONE: begin
        DONE[gidx] = 1'b1;
        MAC_ADDR   = BUF_ADDR[gidx*BUF_AW +: BUF_AW];
        MAC_WD     = BUF_WD[gidx*BUF_DW +: BUF_DW];
        MAC_WE     = BUF_WE[gidx];
        if (!REQ[gidx]) begin
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 2'b00;
      lat_wr_q   <= 1'b0;
      lat_addr_q <= '0;
      lat_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      lat_wr_q   <= lat_wr_d;
      lat_addr_q <= lat_addr_d;
      lat_len_q  <= lat_len_d;
    end
  end

`ifdef SDRAM_SCHED_TMO_EN
  tmo_t tmo_q;
  tmo_t tmo_inc;
  logic in_wait;
  logic err_q;

  assign in_wait = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
  assign tmo_inc = tmo_q + 1'b1;
  // Expire on the edge where the counter would reach all-ones.
  assign tmo_hit = in_wait && (&tmo_inc);
  assign ERR     = err_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ST_SET_LEN) tmo_q <= '0;
      else if (in_wait)          tmo_q <= tmo_inc;
      if (tmo_hit)               err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_sched.sv
// Self-checking bench for sdram_sched: randomized transactions against a grant/field model.
module tb_sdram_sched;

  localparam int TMO_W = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  REQ, REQ_WR, GO, BUF_WE, GNT, DONE;
  logic [47:0] REQ_ADDR;
  logic [17:0] REQ_LEN;
  logic [15:0] BUF_ADDR;
  logic [63:0] BUF_WD;
  logic [31:0] BUF_RD, MAC_WD, MAC_RD;
  logic [7:0]  MAC_ADDR;
  logic        MAC_WE, MAC_WE_LEN, MAC_WE_A, MAC_BUSY, ERR;

  int n_checks = 0;
  int n_err    = 0;
  int last_gnt = 1;  // model: client granted most recently (1 after reset so client 0 wins ties)

  always #5 CLK = ~CLK;

  sdram_sched #(.TMO_W(TMO_W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ        (REQ),
    .REQ_WR     (REQ_WR),
    .GO         (GO),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_LEN    (REQ_LEN),
    .BUF_ADDR   (BUF_ADDR),
    .BUF_WD     (BUF_WD),
    .BUF_WE     (BUF_WE),
    .GNT        (GNT),
    .DONE       (DONE),
    .BUF_RD     (BUF_RD),
    .MAC_ADDR   (MAC_ADDR),
    .MAC_WD     (MAC_WD),
    .MAC_WE     (MAC_WE),
    .MAC_WE_LEN (MAC_WE_LEN),
    .MAC_WE_A   (MAC_WE_A),
    .MAC_RD     (MAC_RD),
    .MAC_BUSY   (MAC_BUSY),
    .ERR        (ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  function automatic int pick(input logic [1:0] m);
    if (m == 2'b11) return 1 - last_gnt;
    return m[0] ? 0 : 1;
  endfunction

  // Drive both buffer ports randomly and confirm only the owner reaches the MAC port.
  task automatic check_buf(input string tag, input int win);
    logic [7:0]  ba[2];
    logic [31:0] bd[2];
    logic        bw[2];
    logic [31:0] rd;
    for (int i = 0; i < 2; i++) begin
      ba[i] = 8'($urandom);
      bd[i] = $urandom;
      bw[i] = 1'($urandom);
    end
    rd       = $urandom;
    BUF_ADDR = {ba[1], ba[0]};
    BUF_WD   = {bd[1], bd[0]};
    BUF_WE   = {bw[1], bw[0]};
    MAC_RD   = rd;
    #1;
    check({tag, "_mac_addr"}, 32'(MAC_ADDR), 32'(ba[win]));
    check({tag, "_mac_wd"},   MAC_WD, bd[win]);
    check({tag, "_mac_we"},   32'(MAC_WE), 32'(bw[win]));
    check({tag, "_buf_rd"},   BUF_RD, rd);
  endtask

  task automatic txn(input logic [1:0] mask, input int busy_pre, input int busy_len,
                     input bit drop_early, input bit fix, input logic [23:0] fa,
                     input logic [8:0] fl, input bit fw);
    logic [23:0] a[2];
    logic [8:0]  l[2];
    logic        w[2];
    logic [31:0] exp_a, exp_l;
    int win;
    for (int i = 0; i < 2; i++) begin
      a[i] = fix ? fa : 24'($urandom);
      l[i] = fix ? fl : 9'($urandom);
      w[i] = fix ? fw : 1'($urandom);
    end
    REQ_ADDR = {a[1], a[0]};
    REQ_LEN  = {l[1], l[0]};
    REQ_WR   = {w[1], w[0]};
    win      = pick(mask);
    exp_a    = {8'h00, a[win]};
    exp_l    = {w[win], 22'h0, l[win]};
    REQ      = mask;
    step();
    check("gnt_own", 32'(GNT), 32'(1 << win));
    check_buf("own", win);
    GO       = 2'b11;
    MAC_BUSY = (busy_pre > 0);
    step();
    GO       = 2'b00;
    REQ_ADDR = 48'({$urandom(), $urandom()});
    REQ_LEN  = 18'($urandom);
    REQ_WR   = ~REQ_WR;
    #1;
    for (int k = 0; k < busy_pre; k++) begin
      check("we_a_held_busy", 32'(MAC_WE_A), 0);
      step();
    end
    MAC_BUSY = 1'b0;
    #1;
    check("we_a", 32'(MAC_WE_A), 1);
    check("wd_addr", MAC_WD, exp_a);
    check("we_only_a", 32'({MAC_WE, MAC_WE_LEN}), 0);
    step();
    check("we_len", 32'(MAC_WE_LEN), 1);
    check("wd_len", MAC_WD, exp_l);
    check("we_only_len", 32'({MAC_WE, MAC_WE_A}), 0);
    step();
    if (drop_early) REQ[win] = 1'b0;
    #1;
    check("we_wait_busy", 32'({MAC_WE, MAC_WE_A, MAC_WE_LEN}), 0);
    MAC_BUSY = 1'b1;
    step();
    for (int k = 0; k < busy_len; k++) begin
      check("done_wait", 32'(DONE), 0);
      check("we_wait_done", 32'({MAC_WE, MAC_WE_A, MAC_WE_LEN}), 0);
      step();
    end
    MAC_BUSY = 1'b0;
    step();
    check("done", 32'(DONE), 32'(1 << win));
    check("gnt_done", 32'(GNT), 32'(1 << win));
    check_buf("done", win);
    if (!drop_early) begin
      step();
      check("done_hold", 32'(DONE), 32'(1 << win));
      REQ[win] = 1'b0;
    end
    step();
    check("gnt_idle", 32'(GNT), 0);
    check("done_idle", 32'(DONE), 0);
    last_gnt = win;
  endtask

  // Bring a transaction from IDLE into WAIT_BUSY with MAC_BUSY then held high.
  task automatic to_wait(output int win);
    REQ_ADDR = 48'({$urandom(), $urandom()});
    REQ_LEN  = 18'($urandom);
    win      = pick(2'b11);
    REQ      = 2'b11;
    step();
    check("gnt_stuck", 32'(GNT), 32'(1 << win));
    GO = 2'b11;
    step();
    GO = 2'b00;
    step();
    step();
    MAC_BUSY = 1'b1;
  endtask

  initial begin
    int win;
    int waits;
    RESET = 1'b1; REQ = '0; REQ_WR = '0; GO = '0; REQ_ADDR = '0; REQ_LEN = '0;
    BUF_ADDR = '0; BUF_WD = '0; BUF_WE = '0; MAC_RD = '0; MAC_BUSY = 1'b0;
    #12;
    check("rst_gnt", 32'(GNT), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_err", 32'(ERR), 0);
    check("rst_we", 32'({MAC_WE, MAC_WE_A, MAC_WE_LEN}), 0);
    check("rst_mac_addr", 32'(MAC_ADDR), 0);
    check("rst_mac_wd", MAC_WD, 0);
    RESET = 1'b0;
    step();

    GO = 2'b11;
    step();
    GO = 2'b00;
    #1;
    check("go_in_idle_gnt", 32'(GNT), 0);
    check("go_in_idle_we_a", 32'(MAC_WE_A), 0);

    txn(2'b01, 0, 2, 1'b0, 1'b1, 24'h012345, 9'd16, 1'b1);

    for (int t = 0; t < 6; t++)
      txn(2'b11, 0, 1 + int'($urandom_range(0, 2)), 1'b0, 1'b0, '0, '0, 1'b0);

    txn(2'b10, 3, 2, 1'b0, 1'b0, '0, '0, 1'b0);
    txn(2'b11, 0, 3, 1'b1, 1'b0, '0, '0, 1'b0);

    for (int t = 0; t < 6; t++)
      txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 1 + int'($urandom_range(0, 3)),
          1'($urandom), 1'b0, '0, '0, 1'b0);
    REQ = 2'b00;
    step();

`ifdef SDRAM_SCHED_TMO_EN
    to_wait(win);
    waits = 0;
    while (DONE == 2'b00 && waits < 40) begin
      waits++;
      step();
    end
    check("tmo_wait_cycles", 32'(waits), 15);
    check("tmo_err", 32'(ERR), 1);
    check("tmo_done", 32'(DONE), 32'(1 << win));
    MAC_BUSY = 1'b0;
    REQ = 2'b00;
    step();
    last_gnt = win;
    check("tmo_err_sticky", 32'(ERR), 1);
    to_wait(win);
    for (int k = 0; k < 6; k++) step();
`else
    to_wait(win);
    for (int k = 0; k < 30; k++) step();
    check("stuck_done", 32'(DONE), 0);
    check("stuck_err", 32'(ERR), 0);
    check("stuck_gnt", 32'(GNT), 32'(1 << win));
`endif

    #2;
    RESET = 1'b1;
    #1;
    check("rst_async_gnt", 32'(GNT), 0);
    check("rst_async_done", 32'(DONE), 0);
    check("rst_async_err", 32'(ERR), 0);
    check("rst_async_we", 32'({MAC_WE, MAC_WE_A, MAC_WE_LEN}), 0);
    check("rst_async_wd", MAC_WD, 0);
    REQ = 2'b00;
    MAC_BUSY = 1'b0;
    #10;
    RESET = 1'b0;
    last_gnt = 1;
    step();
    txn(2'b11, 0, 1, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
